// File: rtl/lfsr_stream_pkg.sv
// Shared definitions for the lfsr_stream block.
// Holds the controller state enum and the width-generic Galois single-step and
// stuck-state helpers. Words are carried zero-extended to MaxBits; nbits selects
// the live width.
package lfsr_stream_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWarm = 2'd1,
        StRun  = 2'd2
    } lfsr_state_e;

    localparam int unsigned MaxBits = 64;

    typedef logic [MaxBits-1:0] lfsr_word_t;

    // One Galois step: shift left, fold in taps when the (optionally inverted) MSB is set.
    function automatic lfsr_word_t lfsr_step(input lfsr_word_t  s,
                                             input lfsr_word_t  taps,
                                             input int unsigned nbits,
                                             input logic        invert);
        lfsr_word_t mask;
        lfsr_word_t msb_sh;
        logic       f;
        mask   = (nbits >= MaxBits) ? '1 : ((lfsr_word_t'(1) << nbits) - lfsr_word_t'(1));
        msb_sh = s >> (nbits - 1);
        f      = msb_sh[0] ^ invert;
        return ((s << 1) ^ (f ? taps : '0)) & mask;
    endfunction

    // A stuck state maps onto itself, so the register would never move again.
    function automatic logic lfsr_is_stuck(input lfsr_word_t  s,
                                           input lfsr_word_t  taps,
                                           input int unsigned nbits,
                                           input logic        invert);
        return lfsr_step(s, taps, nbits, invert) == s;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Output stream handshake of lfsr_stream.
//   out_data  : STEP bits, out_data[STEP-1] is the oldest bit
//   out_valid : out_data valid
//   out_ready : consumer accepts when out_valid & out_ready
// master = producer (lfsr_stream), slave = consumer.
interface lfsr_stream_if #(
    parameter int unsigned STEP = 1
) ();
    logic [STEP-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_stream_step_unroll.sv
// Combinational STEP-fold Galois advance.
//   state_i : current register value
//   next_o  : value after STEP single steps
//   bits_o  : bits_o[STEP-1-k] = MSB of the state after k steps (k = 0..STEP-1)
module lfsr_stream_step_unroll
    import lfsr_stream_pkg::*;
#(
    parameter int unsigned      NBITS  = 8,
    parameter logic [NBITS-1:0] TAPS   = 8'b00011101,
    parameter bit               INVERT = 1'b0,
    parameter int unsigned      STEP   = 1
) (
    input  logic [NBITS-1:0] state_i,
    output logic [NBITS-1:0] next_o,
    output logic [STEP-1:0]  bits_o
);

    always_comb begin
        logic [NBITS-1:0] cur;
        logic [STEP-1:0]  bits;
        cur  = state_i;
        bits = '0;
        for (int k = 0; k < int'(STEP); k++) begin
            // Shift in oldest-first so the first MSB ends up at bits[STEP-1].
            bits = (bits << 1) | STEP'(cur[NBITS-1]);
            cur  = NBITS'(lfsr_step(lfsr_word_t'(cur), lfsr_word_t'(TAPS), NBITS, INVERT));
        end
        next_o = cur;
        bits_o = bits;
    end

endmodule

// File: rtl/lfsr_stream.sv
// Galois LFSR pseudo-random bit-stream source with valid/ready output.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : level, run while high
//   seed_load    : pulse, load seed_in and restart (wins over everything but reset)
//   seed_in      : runtime seed; a stuck seed is replaced by SEED
//   out_if       : out_data / out_valid / out_ready stream (master side)
//   lockup       : 1-cycle pulse, stuck seed replaced by SEED
//   wrap         : 1-cycle pulse, register returned to its RUN-entry value
//   busy         : controller not idle
module lfsr_stream
    import lfsr_stream_pkg::*;
#(
    parameter int unsigned      NBITS  = 8,
    parameter logic [NBITS-1:0] TAPS   = 8'b00011101,
    parameter bit               INVERT = 1'b0,
    parameter int unsigned      STEP   = 1,
    parameter logic [NBITS-1:0] SEED   = {NBITS{1'b1}},
    parameter int unsigned      WARMUP = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [NBITS-1:0] seed_in,
    lfsr_stream_if.master    out_if,
    output logic             lockup,
    output logic             wrap,
    output logic             busy
);

    localparam int unsigned      CntW       = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CntW-1:0]  CntReload  = (WARMUP > 0) ? CntW'(WARMUP - 1) : '0;
    localparam lfsr_state_e      StartState = (WARMUP > 0) ? StWarm : StRun;

    if (NBITS < 3 || NBITS > MaxBits) begin : g_bad_nbits
        $error("lfsr_stream: NBITS out of range");
    end
    if (STEP < 1 || STEP > NBITS) begin : g_bad_step
        $error("lfsr_stream: STEP must be in 1..NBITS");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_stream: TAPS must be non-zero");
    end
    if (lfsr_is_stuck(lfsr_word_t'(SEED), lfsr_word_t'(TAPS), NBITS, INVERT)) begin : g_bad_seed
        $error("lfsr_stream: SEED is a stuck state");
    end

    lfsr_state_e      state_q, state_d;
    logic [NBITS-1:0] lfsr_q, lfsr_d;
    logic [NBITS-1:0] snap_q, snap_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic             load_q, load_d;

    logic [NBITS-1:0] adv_state;
    logic [STEP-1:0]  adv_bits;
    logic             out_valid;
    logic             accept;
    logic             seed_stuck;

    lfsr_stream_step_unroll #(
        .NBITS  (NBITS),
        .TAPS   (TAPS),
        .INVERT (INVERT),
        .STEP   (STEP)
    ) u_unroll (
        .state_i (lfsr_q),
        .next_o  (adv_state),
        .bits_o  (adv_bits)
    );

    assign accept     = out_valid & out_if.out_ready;
    assign seed_stuck = lfsr_is_stuck(lfsr_word_t'(seed_in), lfsr_word_t'(TAPS), NBITS, INVERT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            lfsr_q   <= SEED;
            snap_q   <= SEED;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
            load_q   <= load_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = enable ? StartState : StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (enable) state_d = StartState;
                StWarm: begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (cnt_q == '0) begin
                        state_d = StRun;
                    end
                end
                // A withdrawn-enable only leaves RUN once no word is stalled.
                StRun: if (!enable && !(out_valid && !out_if.out_ready)) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath: register, warm counter, snapshot, pulses.
    always_comb begin
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        load_d   = seed_load;
        if (seed_load) begin
            lfsr_d   = seed_stuck ? SEED : seed_in;
            lockup_d = seed_stuck;
            cnt_d    = CntReload;
        end else begin
            unique case (state_q)
                StIdle: cnt_d = CntReload;
                StWarm: begin
                    if (enable) begin
                        lfsr_d = adv_state;
                        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
                    end
                end
                StRun: begin
                    if (accept) begin
                        lfsr_d = adv_state;
                        wrap_d = (adv_state == snap_q);
                    end
                end
                default: ;
            endcase
        end
        // Capture the value the register holds on the first RUN cycle.
        if (state_d == StRun && (state_q != StRun || seed_load)) begin
            snap_d = lfsr_d;
        end
    end

    // Outputs. The cycle after a seed load never presents a word.
    always_comb begin
        out_valid        = (state_q == StRun) && !load_q;
        out_if.out_valid = out_valid;
        out_if.out_data  = adv_bits;
        busy             = (state_q != StIdle);
        lockup           = lockup_q;
        wrap             = wrap_q;
    end

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed-plus-random bench for lfsr_stream: a STEP=1 default instance (a), a STEP=8
// instance (b) and a WARMUP=4 instance (c), checked against a bit-sequence model.
module tb_lfsr_stream;
    import lfsr_stream_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic       en_a = 0, ld_a = 0, lock_a, wrap_a, busy_a;
    logic       en_b = 0, ld_b = 0, lock_b, wrap_b, busy_b;
    logic       en_c = 0, ld_c = 0, lock_c, wrap_c, busy_c;
    logic [7:0] sd_a = 0, sd_b = 0, sd_c = 0;

    lfsr_stream_if #(.STEP(1)) if_a ();
    lfsr_stream_if #(.STEP(8)) if_b ();
    lfsr_stream_if #(.STEP(1)) if_c ();

    lfsr_stream u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .seed_load(ld_a), .seed_in(sd_a),
        .out_if(if_a), .lockup(lock_a), .wrap(wrap_a), .busy(busy_a)
    );
    lfsr_stream #(.STEP(8)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .seed_load(ld_b), .seed_in(sd_b),
        .out_if(if_b), .lockup(lock_b), .wrap(wrap_b), .busy(busy_b)
    );
    lfsr_stream #(.WARMUP(4)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .enable(en_c), .seed_load(ld_c), .seed_in(sd_c),
        .out_if(if_c), .lockup(lock_c), .wrap(wrap_c), .busy(busy_c)
    );

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] m_a;
    int         acc_a;
    logic       exp_wrap_a;
    int         wraps_a;
    logic       seq_bits [255];

    function automatic logic [7:0] mstep(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_a(input int n);
        logic rdy;
        for (int i = 0; i < n; i++) begin
            chk("a_valid", 64'(if_a.out_valid), 64'd1);
            chk("a_data", 64'(if_a.out_data), 64'(m_a[7]));
            chk("a_lfsr", 64'(u_dut_a.lfsr_q), 64'(m_a));
            chk("a_wrap", 64'(wrap_a), 64'(exp_wrap_a));
            chk("a_lockup", 64'(lock_a), 64'd0);
            if (wrap_a) wraps_a++;
            rdy = ($urandom_range(0, 3) != 0);
            if_a.out_ready = rdy;
            tick();
            if (rdy) begin
                m_a = mstep(m_a);
                acc_a++;
                exp_wrap_a = (acc_a % 255 == 0);
            end else begin
                exp_wrap_a = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] s, r1, r2, exp_byte;
        int         acc_b, wraps_b;
        logic       exp_wrap_b, rdy;

        if_a.out_ready = 0;
        if_b.out_ready = 0;
        if_c.out_ready = 0;

        // 1: asynchronous reset mid-clock, then idle with enable low
        #12 reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_lfsr", 64'(u_dut_a.lfsr_q), 64'hFF);
        chk("rst_lockup", 64'(lock_a), 64'd0);
        chk("rst_wrap", 64'(wrap_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_busy", 64'(busy_a), 64'd0);
        chk("idle_valid", 64'(if_a.out_valid), 64'd0);
        chk("idle_lfsr", 64'(u_dut_a.lfsr_q), 64'hFF);
        chk("idle_busy_b", 64'(busy_b), 64'd0);
        chk("idle_busy_c", 64'(busy_c), 64'd0);

        // 2: free run with random back-pressure; wrap every 255 accepts
        en_a = 1'b1;
        tick();
        chk("t2_valid0", 64'(if_a.out_valid), 64'd1);
        chk("t2_data0", 64'(if_a.out_data), 64'd1);
        if_a.out_ready = 1'b1;
        tick();
        chk("t2_lfsr1", 64'(u_dut_a.lfsr_q), 64'hE3);
        tick();
        chk("t2_lfsr2", 64'(u_dut_a.lfsr_q), 64'hDB);
        m_a = 8'hDB;
        acc_a = 2;
        exp_wrap_a = 1'b0;
        wraps_a = 0;
        run_a(900);
        chk("t2_wrap_last", 64'(wrap_a), 64'(exp_wrap_a));
        if (wrap_a) wraps_a++;
        chk("t2_wrap_count", 64'(wraps_a), 64'(acc_a / 255));

        // 3: stall holds the word; enable drop waits for the accept
        if_a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid", 64'(if_a.out_valid), 64'd1);
            chk("t3_data", 64'(if_a.out_data), 64'(m_a[7]));
            chk("t3_lfsr", 64'(u_dut_a.lfsr_q), 64'(m_a));
        end
        en_a = 1'b0;
        tick();
        chk("t3_hold_valid", 64'(if_a.out_valid), 64'd1);
        chk("t3_hold_busy", 64'(busy_a), 64'd1);
        chk("t3_hold_lfsr", 64'(u_dut_a.lfsr_q), 64'(m_a));
        if_a.out_ready = 1'b1;
        tick();
        m_a = mstep(m_a);
        acc_a++;
        if_a.out_ready = 1'b0;
        chk("t3_idle_busy", 64'(busy_a), 64'd0);
        chk("t3_idle_valid", 64'(if_a.out_valid), 64'd0);
        chk("t3_idle_lfsr", 64'(u_dut_a.lfsr_q), 64'(m_a));
        chk("t3_idle_wrap", 64'(wrap_a), 64'(acc_a % 255 == 0));

        // 4: stuck seed recovery, runtime seed, load beating an accept
        en_a = 1'b1; ld_a = 1'b1; sd_a = 8'h00;
        tick();
        chk("t4_lockup", 64'(lock_a), 64'd1);
        chk("t4_lfsr_ff", 64'(u_dut_a.lfsr_q), 64'hFF);
        chk("t4_valid0", 64'(if_a.out_valid), 64'd0);
        chk("t4_busy", 64'(busy_a), 64'd1);
        ld_a = 1'b0;
        tick();
        chk("t4_lockup_end", 64'(lock_a), 64'd0);
        chk("t4_valid1", 64'(if_a.out_valid), 64'd1);
        chk("t4_data_ff", 64'(if_a.out_data), 64'd1);
        ld_a = 1'b1; sd_a = 8'h5A;
        tick();
        chk("t4_lockup_5a", 64'(lock_a), 64'd0);
        chk("t4_lfsr_5a", 64'(u_dut_a.lfsr_q), 64'h5A);
        chk("t4_valid_5a", 64'(if_a.out_valid), 64'd0);
        ld_a = 1'b0;
        tick();
        m_a = 8'h5A; acc_a = 0; exp_wrap_a = 1'b0;
        run_a(300);
        r1 = 8'($urandom_range(1, 255));
        if_a.out_ready = 1'b1; ld_a = 1'b1; sd_a = r1;
        tick();
        ld_a = 1'b0; if_a.out_ready = 1'b0;
        chk("t4_ldacc_lfsr", 64'(u_dut_a.lfsr_q), 64'(r1));
        chk("t4_ldacc_valid", 64'(if_a.out_valid), 64'd0);
        chk("t4_ldacc_wrap", 64'(wrap_a), 64'd0);
        chk("t4_ldacc_lock", 64'(lock_a), 64'd0);

        // 5: STEP=8 bytes are 8 consecutive single-step bits, oldest in the MSB
        s = 8'hFF;
        for (int j = 0; j < 255; j++) begin
            seq_bits[j] = s[7];
            s = mstep(s);
        end
        en_b = 1'b1;
        tick();
        acc_b = 0; wraps_b = 0; exp_wrap_b = 1'b0;
        for (int i = 0; i < 600 && acc_b < 300; i++) begin
            for (int k = 0; k < 8; k++) exp_byte[7-k] = seq_bits[(acc_b * 8 + k) % 255];
            chk("t5_valid", 64'(if_b.out_valid), 64'd1);
            chk("t5_byte", 64'(if_b.out_data), 64'(exp_byte));
            chk("t5_wrap", 64'(wrap_b), 64'(exp_wrap_b));
            if (wrap_b) wraps_b++;
            rdy = ($urandom_range(0, 7) != 0);
            if_b.out_ready = rdy;
            tick();
            if (rdy) begin
                acc_b++;
                exp_wrap_b = (acc_b % 255 == 0);
            end else begin
                exp_wrap_b = 1'b0;
            end
        end
        chk("t5_wrap_last", 64'(wrap_b), 64'(exp_wrap_b));
        if (wrap_b) wraps_b++;
        chk("t5_wrap_count", 64'(wraps_b), 64'(acc_b / 255));

        // 6: WARMUP=4 discards four advances; a load during WARM restarts the count
        en_c = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t6_warm_valid", 64'(if_c.out_valid), 64'd0);
            chk("t6_warm_busy", 64'(busy_c), 64'd1);
        end
        tick();
        s = mstep(mstep(mstep(mstep(8'hFF))));
        chk("t6_first_valid", 64'(if_c.out_valid), 64'd1);
        chk("t6_first_lfsr", 64'(u_dut_c.lfsr_q), 64'(s));
        chk("t6_first_data", 64'(if_c.out_data), 64'(s[7]));
        r1 = 8'($urandom_range(1, 255));
        r2 = 8'($urandom_range(1, 255));
        ld_c = 1'b1; sd_c = r1;
        tick();
        ld_c = 1'b0;
        chk("t6_ld1_lfsr", 64'(u_dut_c.lfsr_q), 64'(r1));
        chk("t6_ld1_valid", 64'(if_c.out_valid), 64'd0);
        tick(); tick();
        chk("t6_warm2_lfsr", 64'(u_dut_c.lfsr_q), 64'(mstep(mstep(r1))));
        ld_c = 1'b1; sd_c = r2;
        tick();
        ld_c = 1'b0;
        chk("t6_ld2_lfsr", 64'(u_dut_c.lfsr_q), 64'(r2));
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t6_rewarm_valid", 64'(if_c.out_valid), 64'd0);
        end
        tick();
        s = mstep(mstep(mstep(mstep(r2))));
        chk("t6_re_valid", 64'(if_c.out_valid), 64'd1);
        chk("t6_re_lfsr", 64'(u_dut_c.lfsr_q), 64'(s));
        chk("t6_re_data", 64'(if_c.out_data), 64'(s[7]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
